// File: rtl/ecg_sample_player.sv
// Replays a stored ECG recording from memory as a paced valid/ready sample stream.
// Latency: pacing tick -> sample_valid_o in 2 cycles (read strobe issued in the tick cycle).
// Backpressure: a held sample absorbs late ticks and sets sticky overrun_o; no sample is skipped.
module ecg_sample_player #(
    parameter int DATA_WIDTH = 11,
    parameter int LENGTH     = 21600,
    parameter int ADDR_WIDTH = 15,
    parameter int TICK_DIV   = 277777
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  loop_i,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] sample_o,
    output logic [ADDR_WIDTH-1:0] sample_idx_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]         TICK_MAX = CW'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        READ    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]   idx, idx_nxt, idx_inc, rd_addr, addr_q;
    logic                    busy, tick, go, rd, ovr_nxt;

    assign busy    = (state == WAIT) || (state == READ) || (state == PRESENT);
    assign tick    = busy && (cnt == TICK_MAX);
    assign idx_inc = (idx == LAST) ? '0 : idx + 1'b1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ovr_nxt   = overrun_o;
        go        = 1'b0;
        rd        = 1'b0;
        rd_addr   = idx;
        if (stop_i) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_nxt = WAIT;
                        idx_nxt   = '0;
                        ovr_nxt   = 1'b0;
                        go        = 1'b1;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        state_nxt = READ;
                        rd        = 1'b1;
                    end
                end
                READ: state_nxt = PRESENT;
                PRESENT: begin
                    if (sample_ready_i) begin
                        if ((idx == LAST) && !loop_i) begin
                            state_nxt = DONE;
                        end else begin
                            // a tick landing on the handshake fetches the next sample at once
                            idx_nxt = idx_inc;
                            rd_addr = idx_inc;
                            if (tick) begin
                                state_nxt = READ;
                                rd        = 1'b1;
                            end else begin
                                state_nxt = WAIT;
                            end
                        end
                    end else if (tick) begin
                        ovr_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            addr_q       <= '0;
            overrun_o    <= 1'b0;
            sample_o     <= '0;
            sample_idx_o <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            overrun_o <= ovr_nxt;
            if (go || !busy) begin
                cnt <= '0;
            end else begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            if (rd) begin
                addr_q <= rd_addr;
            end
            if ((state == READ) && !stop_i) begin
                sample_o     <= mem_data_i;
                sample_idx_o <= idx;
            end
        end
    end

    assign mem_rd_o       = rd;
    assign mem_addr_o     = rd ? rd_addr : addr_q;
    assign sample_valid_o = (state == PRESENT);
    assign busy_o         = busy;
    assign done_o         = (state == DONE);

endmodule

// File: tb/tb_ecg_sample_player.sv
// Bench for ecg_sample_player: randomized control/backpressure against a time-based reference model.
module tb_ecg_sample_player;

    localparam int DW = 11;
    localparam int L  = 4;
    localparam int AW = 3;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, loop_en = 1'b0, ready = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] sample;
    logic [AW-1:0] sample_idx;
    logic          valid, busy, done, overrun;

    logic [DW-1:0] mem [L];

    int n_chk = 0;
    int n_fail = 0;

    // reference model: ticks every TD cycles after the start cycle, fetch visible 2 cycles later
    int cyc = 0;
    bit m_run, m_done, m_ovr, m_pres, last_rd;
    int t0, nxt, pres_idx, fetch_at, fetch_idx;

    ecg_sample_player #(
        .DATA_WIDTH(DW), .LENGTH(L), .ADDR_WIDTH(AW), .TICK_DIV(TD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .loop_i         (loop_en),
        .mem_rd_o       (mem_rd),
        .mem_addr_o     (mem_addr),
        .mem_data_i     (mem_data),
        .sample_o       (sample),
        .sample_idx_o   (sample_idx),
        .sample_valid_o (valid),
        .sample_ready_i (ready),
        .busy_o         (busy),
        .done_o         (done),
        .overrun_o      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= (mem_addr < AW'(L)) ? mem[mem_addr[1:0]] : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_ovr = 0; m_pres = 0; last_rd = 0;
        t0 = 0; nxt = 0; pres_idx = 0; fetch_at = -1; fetch_idx = 0;
    endtask

    task automatic step(input bit st, input bit sp, input bit lp, input bit rdy);
        bit tick, xfer, e_rd;
        int e_addr;
        @(negedge clk);
        start = st; stop = sp; loop_en = lp; ready = rdy;
        #1;
        check("valid", valid, m_pres);
        if (m_pres) begin
            check("sample", sample, mem[pres_idx]);
            check("sample_idx", sample_idx, pres_idx);
        end
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("overrun", overrun, m_ovr);
        tick = m_run && (cyc > t0) && ((cyc - t0) % TD == 0);
        e_rd = 0; e_addr = 0;
        if (sp) begin
            m_run = 0; m_done = 0; m_pres = 0; fetch_at = -1; nxt = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_done = 0; m_ovr = 0; t0 = cyc; nxt = 0;
            end
        end else begin
            xfer = m_pres && rdy;
            if (xfer) begin
                m_pres = 0;
                if (pres_idx == L - 1 && !lp) begin
                    m_run = 0; m_done = 1;
                end else begin
                    nxt = (pres_idx + 1) % L;
                end
            end else if (tick && m_pres) begin
                m_ovr = 1;
            end
            if (m_run && tick && !m_pres && fetch_at < 0) begin
                e_rd = 1; e_addr = nxt; fetch_at = cyc + 2; fetch_idx = nxt;
            end
            if (fetch_at == cyc + 1) begin
                m_pres = 1; pres_idx = fetch_idx; fetch_at = -1;
            end
        end
        check("mem_rd", mem_rd, e_rd);
        if (e_rd) check("mem_addr", mem_addr, e_addr);
        last_rd = e_rd;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_sample"}, sample, 0);
        check({tag, "_idx"}, sample_idx, 0);
        check({tag, "_rd"}, mem_rd, 0);
        check({tag, "_addr"}, mem_addr, 0);
    endtask

    initial begin
        mem[0] = 11'd100; mem[1] = 11'd200; mem[2] = 11'd300; mem[3] = 11'd400;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // single playback at full rate, then DONE
        step(1, 0, 0, 1);
        repeat (24) step(0, 0, 0, 1);
        check("done_after_play", done, 1);
        check("busy_after_play", busy, 0);

        // looping playback
        step(1, 0, 1, 1);
        repeat (40) step(0, 0, 1, 1);
        step(0, 1, 1, 1);

        // sustained backpressure on sample 200, then released on a tick
        step(1, 0, 0, 1);
        repeat (9) step(0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0);
        check("overrun_held", overrun, 1);
        repeat (12) step(0, 0, 0, 1);

        // start+stop together in IDLE, start while busy, stop in PRESENT
        step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1);

        // randomized control and backpressure
        repeat (3000) step($urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0,
                           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);

        // asynchronous reset while a read is outstanding
        step(0, 1, 0, 1);
        step(1, 0, 0, 1);
        begin
            int budget = 20;
            while (!last_rd && budget > 0) begin
                step(0, 0, 0, 1);
                budget--;
            end
            check("read_seen", last_rd, 1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midread");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(1, 0, 0, 1);
        repeat (12) step(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
